// File: rtl/mem_write_buffer_ctrl_if.sv
// mem_write_buffer_ctrl_if: cache-side request/response bus and SRAM port of the write-buffer controller
interface mem_write_buffer_ctrl_if;
    logic [15:0] memAddr;
    logic        memRead;
    logic        memWrite;
    logic [7:0]  wrData;
    logic [7:0]  dataOut;
    logic        validMemData;
    logic        wrFull;
    logic [15:0] sramAddr;
    logic [7:0]  sramWData;
    logic        sramWE;
    logic        sramRE;
    logic [7:0]  sramRData;
    modport master (
        output memAddr, memRead, memWrite, wrData, sramRData,
        input  dataOut, validMemData, wrFull, sramAddr, sramWData, sramWE, sramRE
    );
    modport slave (
        input  memAddr, memRead, memWrite, wrData, sramRData,
        output dataOut, validMemData, wrFull, sramAddr, sramWData, sramWE, sramRE
    );
endinterface

// File: rtl/mem_write_buffer_ctrl.sv
// mem_write_buffer_ctrl: services cache block-fill reads from SRAM, posts write-through stores in a FIFO
// and forwards buffered bytes to reads that hit them.
module mem_write_buffer_ctrl #(
    parameter int DEPTH    = 4,
    parameter int READ_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_write_buffer_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, FWD} state_t;

    state_t        state, nextState;
    logic [15:0]   addrQ [DEPTH];
    logic [7:0]    dataQ [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr, idx;
    logic [CW-1:0] count;
    logic [LW-1:0] latCnt, nextLatCnt;
    logic [7:0]    rdByte, nextRdByte, hitByte;
    logic          push, pop, hit;

    assign bus.wrFull       = rst && count == CW'(DEPTH);
    assign push             = rst && bus.memWrite && !bus.wrFull;
    assign bus.validMemData = rst && (state == RD_DONE || state == FWD);
    assign bus.dataOut      = bus.validMemData ? rdByte : '0;

    // Oldest-to-youngest scan so the last match wins; a same-cycle write shares memAddr and is youngest of all.
    always_comb begin
        hit = 1'b0;
        hitByte = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr + PW'(i);
            if (CW'(i) < count && addrQ[idx] == bus.memAddr) begin
                hit = 1'b1;
                hitByte = dataQ[idx];
            end
        end
        if (push) begin
            hit = 1'b1;
            hitByte = bus.wrData;
        end
    end

    always_comb begin
        nextState = state;
        nextLatCnt = latCnt;
        nextRdByte = rdByte;
        pop = 1'b0;
        bus.sramRE = 1'b0;
        bus.sramWE = 1'b0;
        bus.sramAddr = '0;
        bus.sramWData = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (bus.memRead && hit) begin
                        nextState = FWD;
                        nextRdByte = hitByte;
                    end else if (bus.memRead) begin
                        bus.sramRE = 1'b1;
                        bus.sramAddr = bus.memAddr;
                        nextState = RD_WAIT;
                        nextLatCnt = LW'(READ_LAT - 1);
                    end else if (count != '0) begin
                        pop = 1'b1;
                        bus.sramWE = 1'b1;
                        bus.sramAddr = addrQ[rdPtr];
                        bus.sramWData = dataQ[rdPtr];
                    end
                end
                RD_WAIT: begin
                    nextState = latCnt == '0 ? RD_DONE : RD_WAIT;
                    nextRdByte = latCnt == '0 ? bus.sramRData : rdByte;
                    nextLatCnt = latCnt == '0 ? latCnt : latCnt - 1'b1;
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            latCnt <= '0;
            rdByte <= '0;
        end else begin
            state <= nextState;
            latCnt <= nextLatCnt;
            rdByte <= nextRdByte;
            rdPtr <= pop ? rdPtr + 1'b1 : rdPtr;
            wrPtr <= push ? wrPtr + 1'b1 : wrPtr;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addrQ[wrPtr] <= bus.memAddr;
            dataQ[wrPtr] <= bus.wrData;
        end
    end
endmodule

// File: tb/tb_mem_write_buffer_ctrl.sv
// tb_mem_write_buffer_ctrl: table vectors, directed corner sequences and a randomized run checked
// against a queue-based model of the write buffer and a golden byte memory.
module tb_mem_write_buffer_ctrl;
    localparam int DEPTH = 4;
    localparam int RL    = 2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic        eFull;
        logic        eWE;
        logic        eRE;
        logic        eV;
        logic [15:0] eAddr;
        logic [7:0]  eWD;
        logic [7:0]  eDO;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nTests = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    mem_write_buffer_ctrl_if bus();
    mem_write_buffer_ctrl #(.DEPTH(DEPTH), .READ_LAT(RL)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [7:0] initVal(input logic [15:0] a);
        return a == 16'h1234 ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    // SRAM model: READ_LAT-deep read pipe, unwritten bytes hold initVal
    logic [7:0] sram [65536];
    bit         written [65536];
    logic [7:0] pipe [RL];
    logic [7:0] shadow [65536];
    assign bus.sramRData = pipe[RL-1];

    always @(posedge clk) begin
        if (bus.sramWE) begin
            sram[bus.sramAddr] <= bus.sramWData;
            written[bus.sramAddr] <= 1'b1;
        end
        pipe[0] <= bus.sramRE ? (written[bus.sramAddr] ? sram[bus.sramAddr] : initVal(bus.sramAddr)) : 8'hEE;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setIn(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        bus.memRead = rd;
        bus.memWrite = wr;
        bus.memAddr = a;
        bus.wrData = d;
    endtask

    task automatic chkZero(input string tag);
        check({tag, " dataOut"}, 32'(bus.dataOut), 0);
        check({tag, " validMemData"}, 32'(bus.validMemData), 0);
        check({tag, " wrFull"}, 32'(bus.wrFull), 0);
        check({tag, " sramWE"}, 32'(bus.sramWE), 0);
        check({tag, " sramRE"}, 32'(bus.sramRE), 0);
        check({tag, " sramAddr"}, 32'(bus.sramAddr), 0);
        check({tag, " sramWData"}, 32'(bus.sramWData), 0);
    endtask

    vec_t tbl [18];

    initial begin
        logic [23:0] q [$];
        logic [15:0] drA [$];
        logic [7:0]  drD [$];
        int acceptCyc [5];
        int firstDrain;
        bit sawV, sawW, sawF;
        tbl[0]  = '{1'b0, 1'b1, 16'h0042, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 16'h0042, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 8'h3C, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 16'h0042, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 16'h0042, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h7E};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 8'h7E, 8'h00};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 8'h00};
        tbl[7]  = '{1'b1, 1'b1, 16'h0A01, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[8]  = '{1'b1, 1'b1, 16'h0A02, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 16'h0A03, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 8'hA5};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0A01, 8'h11, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0A02, 8'h22, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0A03, 8'h33, 8'h00};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[14] = '{1'b1, 1'b1, 16'h0A05, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[15] = '{1'b1, 1'b0, 16'h0A05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h5C};
        tbl[16] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0A05, 8'h5C, 8'h00};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
        for (int i = 0; i < 65536; i++) shadow[i] = initVal(16'(i));
        setIn(1'b0, 1'b0, 16'h0000, 8'h00);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chkZero("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // table vectors: forwarding, miss read latency, drain order, same-cycle forward
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1 setIn(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
            if (tbl[i].wr) shadow[tbl[i].a] = tbl[i].d;
            @(negedge clk);
            check($sformatf("row%0d wrFull", i), 32'(bus.wrFull), 32'(tbl[i].eFull));
            check($sformatf("row%0d sramWE", i), 32'(bus.sramWE), 32'(tbl[i].eWE));
            check($sformatf("row%0d sramRE", i), 32'(bus.sramRE), 32'(tbl[i].eRE));
            check($sformatf("row%0d validMemData", i), 32'(bus.validMemData), 32'(tbl[i].eV));
            check($sformatf("row%0d sramAddr", i), 32'(bus.sramAddr), 32'(tbl[i].eAddr));
            check($sformatf("row%0d sramWData", i), 32'(bus.sramWData), 32'(tbl[i].eWD));
            check($sformatf("row%0d dataOut", i), 32'(bus.dataOut), 32'(tbl[i].eDO));
        end

        // reset in the middle of a miss read with a pending write
        @(posedge clk);
        #1 setIn(1'b0, 1'b1, 16'h0700, 8'h77);
        @(posedge clk);
        #1 setIn(1'b1, 1'b0, 16'h2000, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chkZero("T1 rst cycle1");
        @(posedge clk);
        @(negedge clk);
        chkZero("T1 rst cycle2");
        @(posedge clk);
        #1 rst = 1'b1;
        setIn(1'b0, 1'b0, 16'h0000, 8'h00);
        sawV = 1'b0;
        sawW = 1'b0;
        sawF = 1'b0;
        repeat (6) begin
            @(negedge clk);
            sawV |= bus.validMemData;
            sawW |= bus.sramWE;
            sawF |= bus.wrFull;
        end
        check("T1 no validMemData after reset", 32'(sawV), 0);
        check("T1 no drain after reset", 32'(sawW), 0);
        check("T1 wrFull after reset", 32'(sawF), 0);

        // back-to-back block fill
        for (int k = 0; k < 16; k++) begin
            int lat;
            lat = -1;
            @(posedge clk);
            #1 setIn(1'b1, 1'b0, 16'h0100 + 16'(k), 8'h00);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (bus.validMemData) begin
                    lat = c;
                    break;
                end
                @(posedge clk);
            end
            check($sformatf("T3 byte%0d latency", k), 32'(lat), RL + 1);
            check($sformatf("T3 byte%0d data", k), 32'(bus.dataOut), 32'(shadow[16'h0100 + 16'(k)]));
        end
        @(posedge clk);
        #1 setIn(1'b0, 1'b0, 16'h0000, 8'h00);

        // fill the buffer while reads block draining; 5th write held until after first drain
        begin
            int k, nValid;
            bit readOn;
            k = 0;
            nValid = 0;
            readOn = 1'b1;
            firstDrain = -1;
            for (int c = 0; c < 40 && !(k == 5 && drA.size() == 5); c++) begin
                @(posedge clk);
                #1 setIn(readOn, k < 5, k < 5 ? 16'h0B00 + 16'(k) : 16'h0000, 8'h40 + 8'(k));
                @(negedge clk);
                if (k == 4 && bus.memWrite && !sawF) begin
                    sawF = 1'b1;
                    check("T4 wrFull on 5th write", 32'(bus.wrFull), 1);
                end
                if (bus.sramWE) begin
                    if (firstDrain < 0) firstDrain = c;
                    drA.push_back(bus.sramAddr);
                    drD.push_back(bus.sramWData);
                end
                if (bus.validMemData && ++nValid == 3) readOn = 1'b0;
                if (bus.memWrite && !bus.wrFull) begin
                    acceptCyc[k] = c;
                    shadow[bus.memAddr] = bus.wrData;
                    k++;
                end
            end
            check("T4 writes accepted", 32'(k), 5);
            check("T4 drain count", 32'(drA.size()), 5);
            for (int i = 0; i < 5 && i < drA.size(); i++) begin
                check($sformatf("T4 drain%0d addr", i), 32'(drA[i]), 32'(16'h0B00 + 16'(i)));
                check($sformatf("T4 drain%0d data", i), 32'(drD[i]), 32'(8'h40 + 8'(i)));
            end
            if (k == 5) check("T4 5th accepted cycle after first drain", 32'(acceptCyc[4]), 32'(firstDrain + 1));
            @(posedge clk);
            #1 setIn(1'b0, 1'b0, 16'h0000, 8'h00);
            repeat (3) @(posedge clk);
        end

        // randomized traffic against a queue model of the buffer and a golden byte memory
        begin
            bit outstanding, held, rd, wr, acc, hit, drainExp;
            int due;
            logic [15:0] a, hA;
            logic [7:0] d, hD, expData;
            outstanding = 1'b0;
            held = 1'b0;
            due = 0;
            expData = '0;
            hA = '0;
            hD = '0;
            for (int c = 0; c < 1500; c++) begin
                @(posedge clk);
                #1;
                if (!outstanding && !held && $urandom_range(0, 2) == 0) begin
                    rd = 1'b1;
                    a = 16'h0A00 + 16'($urandom_range(0, 15));
                    wr = $urandom_range(0, 3) == 0;
                    d = 8'($urandom);
                end else begin
                    rd = outstanding;
                    wr = held || $urandom_range(0, 1) == 1;
                    a = held ? hA : 16'h0A00 + 16'($urandom_range(0, 15));
                    d = held ? hD : 8'($urandom);
                end
                setIn(rd, wr, a, d);
                @(negedge clk);
                check("rand wrFull", 32'(bus.wrFull), 32'(q.size() == DEPTH));
                acc = wr && q.size() != DEPTH;
                held = wr && !acc;
                hA = a;
                hD = d;
                drainExp = !outstanding && !rd && q.size() > 0;
                check("rand sramWE", 32'(bus.sramWE), 32'(drainExp));
                if (drainExp && bus.sramWE) begin
                    check("rand drain addr", 32'(bus.sramAddr), 32'(q[0][23:8]));
                    check("rand drain data", 32'(bus.sramWData), 32'(q[0][7:0]));
                end
                if (drainExp) void'(q.pop_front());
                if (rd && !outstanding) begin
                    hit = acc;
                    foreach (q[i]) if (q[i][23:8] == a) hit = 1'b1;
                    expData = acc ? d : shadow[a];
                    check("rand sramRE on request", 32'(bus.sramRE), 32'(!hit));
                    if (!hit) check("rand read sramAddr", 32'(bus.sramAddr), 32'(a));
                    outstanding = 1'b1;
                    due = c + (hit ? 1 : RL + 1);
                end else begin
                    check("rand sramRE idle", 32'(bus.sramRE), 0);
                end
                check("rand validMemData", 32'(bus.validMemData), 32'(outstanding && c == due));
                if (outstanding && c == due) begin
                    check("rand dataOut", 32'(bus.dataOut), 32'(expData));
                    outstanding = 1'b0;
                end
                if (acc) begin
                    q.push_back({a, d});
                    shadow[a] = d;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
